// File: rtl/program_counter.sv
// Fetch-stage program counter: one register that takes either the sequential
// address or a redirect target on every rising edge, cleared asynchronously by clr.
module program_counter #(
  parameter int               pcen      = 32,
  parameter int               pcout     = 32,
  parameter logic [pcout-1:0] RESET_VEC = {pcout{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_en,
  input  logic [pcen-1:0]  pc_next,
  input  logic [pcen-1:0]  load,
  output logic [pcout-1:0] pc
);

  logic [pcout-1:0] load_ext;
  logic [pcout-1:0] next_ext;
  logic [pcout-1:0] pc_d;
  logic [pcout-1:0] pc_q;

  // Narrow inputs are zero-extended, wide inputs keep only their low pcout bits.
  generate
    if (pcen >= pcout) begin : g_trunc
      assign load_ext = load[pcout-1:0];
      assign next_ext = pc_next[pcout-1:0];
    end else begin : g_zext
      assign load_ext = {{(pcout-pcen){1'b0}}, load};
      assign next_ext = {{(pcout-pcen){1'b0}}, pc_next};
    end
  endgenerate

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_ext;
    end else begin
      pc_d = next_ext;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a 32/32 instance and a 16->32 instance
// share stimulus; expected values are queued by the driver and checked by a monitor.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] load = 32'h0;
  logic [31:0] pc_w;
  logic [15:0] pc_next_n;
  logic [15:0] load_n;
  logic [31:0] pc_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] e_w;
    logic [31:0] e_n;
  } exp_t;
  exp_t sb_q[$];

  assign pc_next_n = pc_next[15:0];
  assign load_n    = load[15:0];

  program_counter #(.pcen(32), .pcout(32)) dut (
    .clk(clk), .clr(clr), .load_en(load_en),
    .pc_next(pc_next), .load(load), .pc(pc_w)
  );

  program_counter #(.pcen(16), .pcout(32)) dut_n (
    .clk(clk), .clr(clr), .load_en(load_en),
    .pc_next(pc_next_n), .load(load_n), .pc(pc_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: reset wins, otherwise the selected address; narrow part keeps 16 bits.
  function automatic exp_t model(input logic c, input logic le,
                                 input logic [31:0] ld, input logic [31:0] nx);
    exp_t r;
    logic [31:0] sel;
    sel = c ? 32'h0 : (le ? ld : nx);
    r.e_w = sel;
    r.e_n = sel % 32'h0001_0000;
    return r;
  endfunction

  // One clock of stimulus; mid_clr raises clr between edges and checks it takes effect at once.
  task automatic cycle(input logic c, input logic le, input logic [31:0] ld,
                       input logic [31:0] nx, input bit mid_clr);
    @(negedge clk);
    load_en = le;
    load    = ld;
    pc_next = nx;
    if (mid_clr) begin
      clr = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      check("mid_clr_w", pc_w, 32'h0);
      check("mid_clr_n", pc_n, 32'h0);
      sb_q.push_back(model(1'b1, le, ld, nx));
    end else begin
      clr = c;
      sb_q.push_back(model(c, le, ld, nx));
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_w", pc_w, e.e_w);
        check("pc_n", pc_n, e.e_n);
      end
    end
  end

  initial begin
    // Reset asserted before the first edge must clear pc immediately.
    #1 clr = 1'b1;
    load = 32'hAA;
    #1;
    check("reset_pre_edge_w", pc_w, 32'h0);
    check("reset_pre_edge_n", pc_n, 32'h0);

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'hAA, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'hAA, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'hAA, 32'h104, 1'b0);

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hAA, 32'h104, 1'b0);
    cycle(1'b0, 1'b0, 32'hAA, 32'h200, 1'b0);
    cycle(1'b0, 1'b1, 32'hAA, 32'h200, 1'b0);

    // Clear between edges while pc=0xAA, then hold clr with load_en asserted.
    cycle(1'b0, 1'b1, 32'hAA, 32'h200, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hAA, 32'h200, 1'b0);
    // clr released with load_en=1: the first edge loads the target.
    cycle(1'b0, 1'b1, 32'h1234_5678, 32'h200, 1'b0);

    for (int i = 0; i < 6; i++) cycle(1'b0, (i % 2) == 0, 32'h1000, 32'h4, 1'b0);

    // Width and all-ones pass-through.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_FFFF, 32'h0, 1'b0);

    // Inputs changed between edges must not disturb the registered value.
    @(negedge clk);
    load    = 32'hDEAD_BEEF;
    pc_next = 32'hCAFE_F00D;
    #1;
    check("hold_between_edges_w", pc_w, 32'h0000_FFFF);
    check("hold_between_edges_n", pc_n, 32'h0000_FFFF);
    sb_q.push_back(model(clr, load_en, load, pc_next));

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 16) == 0, $urandom % 2, $urandom, $urandom, ($urandom % 40) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
